// File: rtl/rd_ptr_empty.sv
// Read-side pointer and empty-flag logic for an asynchronous FIFO.
// Optional almost_empty output is compiled in with macro RD_ALMOST_EMPTY_EN.
module rd_ptr_empty #(
    parameter int ADDR_WIDTH = 4,
    parameter int AE_THRESH  = 2
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH:0]   wr_gray_in,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   rd_gray_out,
    output logic                  empty,
`ifdef RD_ALMOST_EMPTY_EN
    output logic                  almost_empty,
`endif
    output logic                  rd_fire
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wsync1;
    logic [PW-1:0] wsync2;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_bin_next;
    logic [PW-1:0] rd_gray_next;

    // Two-flop synchroniser for the write pointer; only wsync2 is trusted.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            wsync1 <= '0;
            wsync2 <= '0;
        end else begin
            wsync1 <= wr_gray_in;
            wsync2 <= wsync1;
        end
    end

    assign rd_fire      = rd_en & ~empty;
    assign rd_bin_next  = rd_bin + PW'(rd_fire);
    assign rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);
    assign rd_addr      = rd_bin[ADDR_WIDTH-1:0];

    // Empty is computed from the next pointer so the last read flags empty at once.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_bin      <= '0;
            rd_gray_out <= '0;
            empty       <= 1'b1;
        end else begin
            rd_bin      <= rd_bin_next;
            rd_gray_out <= rd_gray_next;
            empty       <= (rd_gray_next == wsync2);
        end
    end

`ifdef RD_ALMOST_EMPTY_EN
    localparam logic [PW-1:0] AE_LIM = PW'(AE_THRESH);

    logic [PW-1:0] wbin_s;
    logic [PW-1:0] occ;

    always_comb begin
        wbin_s = '0;
        for (int i = 0; i < PW; i++) begin
            wbin_s[i] = ^(wsync2 >> i);
        end
    end

    // Occupancy wraps modulo 2^PW, matching the pointer arithmetic.
    assign occ = wbin_s - rd_bin_next;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            almost_empty <= 1'b1;
        end else begin
            almost_empty <= (occ <= AE_LIM);
        end
    end
`endif

endmodule

// File: tb/tb_rd_ptr_empty.sv
// Self-checking bench for rd_ptr_empty: vector table, corner sequences, random vs model.
module tb_rd_ptr_empty;

    localparam int AW   = 4;
    localparam int AE   = 2;
    localparam int MASK = (1 << (AW + 1)) - 1;

    logic          rd_clk = 1'b0;
    logic          rd_rst = 1'b1;
    logic          rd_en  = 1'b0;
    logic [AW:0]   wr_gray_in = '0;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   rd_gray_out;
    logic          empty;
    logic          rd_fire;
`ifdef RD_ALMOST_EMPTY_EN
    logic          almost_empty;
`endif

    rd_ptr_empty #(.ADDR_WIDTH(AW), .AE_THRESH(AE)) dut (
        .rd_clk      (rd_clk),
        .rd_rst      (rd_rst),
        .rd_en       (rd_en),
        .wr_gray_in  (wr_gray_in),
        .rd_addr     (rd_addr),
        .rd_gray_out (rd_gray_out),
        .empty       (empty),
`ifdef RD_ALMOST_EMPTY_EN
        .almost_empty(almost_empty),
`endif
        .rd_fire     (rd_fire)
    );

    always #5 rd_clk = ~rd_clk;

    int errors = 0;
    int checks = 0;

    // Reference model: read count, and the history of write-pointer samples
    // taken at each rd_clk edge; the flag at edge k sees the sample from edge k-2.
    int   rcnt;
    logic emp_m;
    logic ae_m;
    int   hist[$];
    logic fire_pre;

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] v;
        v = b[AW:0];
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        rcnt  = 0;
        emp_m = 1'b1;
        ae_m  = 1'b1;
        hist.delete();
        hist.push_back(0);
        hist.push_back(0);
    endtask

    task automatic do_reset();
        rd_rst = 1'b1;
        rd_en  = 1'b0;
        wr_gray_in = '0;
        repeat (2) @(posedge rd_clk);
        #1;
        rd_rst = 1'b0;
        model_reset();
    endtask

    // One rd_clk cycle: drive, check rd_fire before the edge, update model, check after.
    task automatic step(input logic en, input int wbin);
        int seen;
        int occ;
        rd_en = en;
        wr_gray_in = gray(wbin & MASK);
        #1;
        fire_pre = rd_fire;
        chk("rd_fire", rd_fire, en && !emp_m);
        @(posedge rd_clk);
        seen = hist[$-1];
        if (en && !emp_m) rcnt = (rcnt + 1) & MASK;
        emp_m = (rcnt == seen);
        occ   = (seen - rcnt) & MASK;
        ae_m  = (occ <= AE);
        hist.push_back(wbin & MASK);
        if (hist.size() > 4) void'(hist.pop_front());
        #1;
        chk("rd_addr", rd_addr, rcnt % (1 << AW));
        chk("rd_gray_out", rd_gray_out, gray(rcnt));
        chk("empty", empty, emp_m);
`ifdef RD_ALMOST_EMPTY_EN
        chk("almost_empty", almost_empty, ae_m);
`endif
    endtask

    typedef struct {
        logic rst;
        logic en;
        int   wbin;
        logic fire;
        logic emp;
        int   addr;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int wb;
        // Sync latency with wr=gray(1), then drain of 3 entries after a fresh reset.
        tbl[0]  = '{1'b1, 1'b0, 1, 1'b0, 1'b1, 0};
        tbl[1]  = '{1'b0, 1'b0, 1, 1'b0, 1'b1, 0};
        tbl[2]  = '{1'b0, 1'b0, 1, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b0, 1'b1, 1, 1'b1, 1'b1, 1};
        tbl[4]  = '{1'b0, 1'b1, 1, 1'b0, 1'b1, 1};
        tbl[5]  = '{1'b1, 1'b0, 3, 1'b0, 1'b1, 0};
        tbl[6]  = '{1'b0, 1'b0, 3, 1'b0, 1'b1, 0};
        tbl[7]  = '{1'b0, 1'b0, 3, 1'b0, 1'b0, 0};
        tbl[8]  = '{1'b0, 1'b1, 3, 1'b1, 1'b0, 1};
        tbl[9]  = '{1'b0, 1'b1, 3, 1'b1, 1'b0, 2};
        tbl[10] = '{1'b0, 1'b1, 3, 1'b1, 1'b1, 3};
        tbl[11] = '{1'b0, 1'b1, 3, 1'b0, 1'b1, 3};

        do_reset();
        chk("rst_empty", empty, 1);
        chk("rst_addr", rd_addr, 0);
        chk("rst_gray", rd_gray_out, 0);
`ifdef RD_ALMOST_EMPTY_EN
        chk("rst_ae", almost_empty, 1);
`endif

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].en, tbl[i].wbin);
            chk($sformatf("tbl%0d_fire", i), fire_pre, tbl[i].fire);
            chk($sformatf("tbl%0d_empty", i), empty, tbl[i].emp);
            chk($sformatf("tbl%0d_addr", i), rd_addr, tbl[i].addr);
        end

        // Asynchronous reset mid-stream with rd_bin=5 and rd_en held high.
        do_reset();
        repeat (3) step(1'b0, 8);
        repeat (5) step(1'b1, 8);
        chk("mid_addr5", rd_addr, 5);
        #2;
        rd_en  = 1'b1;
        rd_rst = 1'b1;
        #1;
        chk("mid_rst_addr", rd_addr, 0);
        chk("mid_rst_gray", rd_gray_out, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_fire", rd_fire, 0);
`ifdef RD_ALMOST_EMPTY_EN
        chk("mid_rst_ae", almost_empty, 1);
`endif
        do_reset();

        // Wrap: bring the read pointer to 31, then read across the wrap.
        repeat (3) step(1'b0, 31);
        repeat (31) step(1'b1, 31);
        chk("wrap_pre_addr", rd_addr, 15);
        chk("wrap_pre_gray", rd_gray_out, 5'b10000);
        chk("wrap_pre_empty", empty, 1);
        repeat (3) step(1'b0, 33);
        step(1'b1, 33);
        chk("wrap_addr0", rd_addr, 0);
        chk("wrap_gray0", rd_gray_out, 5'b00000);
        step(1'b1, 33);
        chk("wrap_gray1", rd_gray_out, 5'b00001);
        chk("wrap_empty", empty, 1);

        // Full depth: 16 entries ahead, 16 back-to-back reads.
        do_reset();
        repeat (3) step(1'b0, 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fd_empty%0d", i), empty, 0);
            step(1'b1, 16);
            chk($sformatf("fd_fire%0d", i), fire_pre, 1);
        end
        chk("fd_end_empty", empty, 1);

`ifdef RD_ALMOST_EMPTY_EN
        // Almost-empty: occupancy 4, then two reads bring it to 2.
        do_reset();
        repeat (3) step(1'b0, 4);
        chk("ae_occ4", almost_empty, 0);
        step(1'b1, 4);
        chk("ae_occ3", almost_empty, 0);
        step(1'b1, 4);
        chk("ae_occ2", almost_empty, 1);
`endif

        // Random traffic; the writer never runs more than a full FIFO ahead.
        do_reset();
        wb = 0;
        for (int i = 0; i < 600; i++) begin
            int inc;
            inc = $urandom_range(0, 2);
            if ((((wb + inc) - rcnt) & MASK) <= (1 << AW)) wb = (wb + inc) & MASK;
            step(1'($urandom_range(0, 1)), wb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rd_ptr_empty.md
RD_PTR_EMPTY -- requirements
Module: rd_ptr_empty

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, meaning FIFO address width; pointers are ADDR_WIDTH+1 bits, FIFO depth 2^ADDR_WIDTH.
REQ-002 SHALL have parameter AE_THRESH, default 2, meaning the almost-empty occupancy threshold in entries (used only with REQ-024).
REQ-003 SHALL have port: rd_clk  input  1  read-domain clock; the only clock in the block.
REQ-004 SHALL have port: rd_rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port: rd_en  input  1  read request from the consumer.
REQ-006 SHALL have port: wr_gray_in  input  ADDR_WIDTH+1  write pointer, Gray-coded, driven from the write clock domain (asynchronous to rd_clk).
REQ-007 SHALL have port: rd_addr  output  ADDR_WIDTH  FIFO memory read address.
REQ-008 SHALL have port: rd_gray_out  output  ADDR_WIDTH+1  registered Gray read pointer, sent to the write domain for full detection.
REQ-009 SHALL have port: empty  output  1  registered FIFO-empty flag.
REQ-010 SHALL have port: rd_fire  output  1  accepted read this cycle (combinational).
REQ-011 SHALL have port: almost_empty  output  1  registered; present only when REQ-024 applies.

Function
REQ-012 SHALL synchronise wr_gray_in through two rd_clk flops (wsync1 -> wsync2); only wsync2 is used downstream.
REQ-013 SHALL compute rd_fire = rd_en AND NOT empty; rd_en while empty has no effect on any state.
REQ-014 SHALL hold a binary read pointer rd_bin (ADDR_WIDTH+1 bits); rd_bin_next = rd_bin + rd_fire, wrapping modulo 2^(ADDR_WIDTH+1).
REQ-015 SHALL register rd_bin <= rd_bin_next and rd_gray_out <= rd_bin_next ^ (rd_bin_next >> 1) on every rd_clk rising edge.
REQ-016 SHALL drive rd_addr = rd_bin[ADDR_WIDTH-1:0] from the register, with no combinational path from rd_en.
REQ-017 SHALL register empty <= (gray(rd_bin_next) == wsync2), comparing all ADDR_WIDTH+1 bits; the MSB distinguishes wrap laps.
REQ-018 SHALL deassert empty on the 3rd rd_clk rising edge after a stable wr_gray_in change (2 sync edges + 1 flag edge).
REQ-019 SHALL assert empty on the same edge that consumes the last entry (read of last entry -> empty=1 next cycle, no extra latency).
REQ-020 SHALL tolerate wr_gray_in advancing by any number of single-bit Gray steps between rd_clk edges; empty then reflects the last sampled wsync2 (pessimistic, never falsely non-empty).
REQ-021 SHALL keep pointer wrap seamless: rd_bin from all-ones to 0 with empty behaviour unchanged.

Reset
REQ-022 SHALL, on rd_rst assertion (at any time, including mid-read), asynchronously set wsync1, wsync2, rd_bin and rd_gray_out to 0, empty to 1, and almost_empty (if present) to 1; rd_addr = 0 and rd_fire = 0 follow from this.
REQ-023 SHALL resume normal operation on the first rd_clk rising edge after rd_rst deasserts; the write side is reset by its own domain.

Configuration
REQ-024 SHALL compile in almost_empty only when macro RD_ALMOST_EMPTY_EN is defined: the block converts wsync2 to binary wbin_s and registers almost_empty <= ((wbin_s - rd_bin_next) mod 2^(ADDR_WIDTH+1)) <= AE_THRESH.
REQ-025 SHALL, when RD_ALMOST_EMPTY_EN is undefined, omit the almost_empty port, the Gray-to-binary logic and the subtractor; all other behaviour SHALL be identical.

Verification
REQ-026 SHALL cover reset: rd_rst=1 mid-stream with rd_bin=5 -> immediately rd_bin=0, rd_gray_out=0, empty=1, almost_empty=1; rd_en=1 held -> rd_fire=0.
REQ-027 SHALL cover sync latency: ADDR_WIDTH=4, after reset, wr_gray_in 00000->00001 -> empty falls on the 3rd rd_clk edge, not earlier.
REQ-028 SHALL cover drain: wr_gray_in=gray(3)=00010, rd_en=1 for 4 cycles -> rd_fire=1 for 3 cycles, rd_addr 0,1,2, empty=1 after the 3rd read, rd_bin stays 3.
REQ-029 SHALL cover wrap: preload rd_bin=31 with wr pointer=gray(1) -> two reads, rd_addr 15 then 0, rd_gray_out 10000 -> 00000 -> 00001, empty=1 at end.
REQ-030 SHALL cover full depth: wr pointer 16 ahead (gray(16)=11000) -> 16 consecutive reads, empty=0 throughout until the edge consuming entry 16.
REQ-031 SHALL cover almost_empty (macro defined, AE_THRESH=2): occupancy 4 -> almost_empty=0; after 2 reads occupancy 2 -> almost_empty=1 on the same edge as the 2nd read.
